// File: rtl/tube_pkg.sv
// Shared Tube constants, request bundle and width helpers.
package tube_pkg;
  localparam int TUBE_DATA_W   = 8;
  localparam int HP_FIFO_DEPTH = 2;
  localparam logic [TUBE_DATA_W-1:0] TUBE_RESET_BYTE = 8'h00;

  typedef struct packed {
    logic wr;     // qualified host write strobe
    logic rd;     // qualified parasite read strobe
    logic flush;
  } hp_req_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/hp_count_m.sv
// Occupancy counter and ring pointers for the host-to-parasite buffer.
module hp_count_m
  import tube_pkg::*;
#(
  parameter int DEPTH = HP_FIFO_DEPTH,
  parameter int CW    = cnt_width(DEPTH),
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          two_byte_mode,
  input  hp_req_t       req,
  output logic [CW-1:0] count,
  output logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] wr_ptr,
  output logic          wr_en,
  output logic          available,
  output logic          full,
  output logic          nmi,
  output logic          overrun
);
  logic [CW-1:0] cap;
  logic          wr_ok, rd_ok;

  // Both sides judge against the pre-edge count, so space freed by a
  // same-cycle read is never handed to the writer.
  assign cap       = two_byte_mode ? CW'(DEPTH) : CW'(1);
  assign wr_ok     = req.wr & (count < cap);
  assign rd_ok     = req.rd & (count != '0);
  assign wr_en     = wr_ok & ~req.flush;
  assign full      = count >= cap;
  assign available = count != '0;
  assign nmi       = full & ~req.flush;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      overrun <= 1'b0;
    end else if (req.flush) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= bump(wr_ptr);
      if (rd_ok) rd_ptr <= bump(rd_ptr);
      if (wr_ok & ~rd_ok)      count <= count + CW'(1);
      else if (rd_ok & ~wr_ok) count <= count - CW'(1);
      if (req.wr & ~wr_ok) overrun <= 1'b1;
    end
  end
endmodule

// File: rtl/hp_fifo.sv
// Host-to-parasite Tube data buffer: storage array and head-byte mux.
module hp_fifo
  import tube_pkg::*;
#(
  parameter int               WIDTH      = TUBE_DATA_W,
  parameter int               DEPTH      = HP_FIFO_DEPTH,
  parameter logic [WIDTH-1:0] RESET_DATA = TUBE_RESET_BYTE
) (
  input  logic             p_phi2,
  input  logic             h_rst_b,
  input  logic             two_byte_mode,
  input  logic             h_selectData,
  input  logic             h_rdnw,
  input  logic [WIDTH-1:0] h_data,
  input  logic             p_selectData,
  input  logic             p_rdnw,
  input  logic             p_flush,
  output logic [WIDTH-1:0] p_data,
  output logic             p_data_available,
  output logic             h_full,
  output logic             p_nmi,
  output logic             h_overrun
);
  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  hp_req_t                     req;
  logic [CW-1:0]               count;
  logic [PW-1:0]               rd_ptr, wr_ptr;
  logic                        wr_en;
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  assign req.wr    = h_selectData & ~h_rdnw;
  assign req.rd    = p_selectData & p_rdnw;
  assign req.flush = p_flush;

  hp_count_m #(.DEPTH(DEPTH), .CW(CW), .PW(PW)) u_count (
    .clk           (p_phi2),
    .rst_n         (h_rst_b),
    .two_byte_mode (two_byte_mode),
    .req           (req),
    .count         (count),
    .rd_ptr        (rd_ptr),
    .wr_ptr        (wr_ptr),
    .wr_en         (wr_en),
    .available     (p_data_available),
    .full          (h_full),
    .nmi           (p_nmi),
    .overrun       (h_overrun)
  );

  always_ff @(posedge p_phi2) begin
    if (!h_rst_b) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_DATA;
    end else if (wr_en) begin
      mem[wr_ptr] <= h_data;
    end
  end

  // Head byte is shown even when empty, so a read on empty sees the stale entry.
  assign p_data = mem[rd_ptr];
endmodule

// File: tb/tb_hp_fifo.sv
// Self-checking bench: directed vector table, flush/NMI sequence, random vs queue model.
module tb_hp_fifo;
  logic       p_phi2 = 1'b0;
  logic       h_rst_b = 1'b0;
  logic       two_byte_mode = 1'b0;
  logic       h_selectData = 1'b0;
  logic       h_rdnw = 1'b1;
  logic [7:0] h_data = 8'h00;
  logic       p_selectData = 1'b0;
  logic       p_rdnw = 1'b0;
  logic       p_flush = 1'b0;
  logic [7:0] p_data;
  logic       p_data_available, h_full, p_nmi, h_overrun;

  hp_fifo dut (
    .p_phi2           (p_phi2),
    .h_rst_b          (h_rst_b),
    .two_byte_mode    (two_byte_mode),
    .h_selectData     (h_selectData),
    .h_rdnw           (h_rdnw),
    .h_data           (h_data),
    .p_selectData     (p_selectData),
    .p_rdnw           (p_rdnw),
    .p_flush          (p_flush),
    .p_data           (p_data),
    .p_data_available (p_data_available),
    .h_full           (h_full),
    .p_nmi            (p_nmi),
    .h_overrun        (h_overrun)
  );

  always #5 p_phi2 = ~p_phi2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst_n, mode, wr, rd, flush;
    logic [7:0] d, exp_data;
    logic       exp_av, exp_full, exp_nmi, exp_ovr;
  } vec_t;
  vec_t vecs[$];

  // Reference model: byte queue plus the storage image addressed by running totals.
  logic [7:0] m[2];
  logic [7:0] q[$];
  int         rd_tot, wr_tot;
  bit         ovr;

  task automatic add(input logic rst_n, mode, wr, rd, flush, input logic [7:0] d, ed,
                     input logic av, fu, nm, ov);
    vec_t v;
    v.rst_n = rst_n; v.mode = mode; v.wr = wr; v.rd = rd; v.flush = flush; v.d = d;
    v.exp_data = ed; v.exp_av = av; v.exp_full = fu; v.exp_nmi = nm; v.exp_ovr = ov;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    h_selectData = 1'b0; h_rdnw = 1'b1; p_selectData = 1'b0; p_rdnw = 1'b0; p_flush = 1'b0;
  endtask

  task automatic model_reset();
    m[0] = 8'h00; m[1] = 8'h00; q.delete(); rd_tot = 0; wr_tot = 0; ovr = 0;
  endtask

  task automatic model_step();
    int  n, cap;
    bit  wr, rd;
    if (!h_rst_b) begin
      model_reset();
    end else if (p_flush) begin
      q.delete(); rd_tot = 0; wr_tot = 0; ovr = 0;
    end else begin
      cap = two_byte_mode ? 2 : 1;
      n   = q.size();
      wr  = h_selectData & !h_rdnw;
      rd  = p_selectData & p_rdnw;
      if (rd && n != 0) begin
        void'(q.pop_front());
        rd_tot++;
      end
      if (wr) begin
        if (n < cap) begin
          m[wr_tot % 2] = h_data;
          q.push_back(h_data);
          wr_tot++;
        end else begin
          ovr = 1;
        end
      end
    end
  endtask

  initial begin
    //   rst mode wr rd fl data   p_data av full nmi ovr
    add(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 8'hA5, 8'hA5, 1, 1, 1, 0);
    add(1, 0, 1, 0, 0, 8'h3C, 8'hA5, 1, 1, 1, 1);
    add(1, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 8'h00, 8'hA5, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 8'h11, 8'h11, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 8'h22, 8'h11, 1, 1, 1, 0);
    add(1, 1, 0, 1, 0, 8'h00, 8'h22, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 8'h00, 8'h11, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 8'h33, 8'h33, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 8'h00, 8'h22, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 8'h44, 8'h44, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 8'h55, 8'h55, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 8'h00, 8'h44, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 8'h66, 8'h66, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 8'h77, 8'h66, 1, 1, 1, 0);
    add(1, 1, 1, 1, 0, 8'h88, 8'h77, 1, 0, 0, 1);
    add(1, 1, 1, 0, 0, 8'h99, 8'h77, 1, 1, 1, 1);
    add(1, 0, 0, 0, 0, 8'h00, 8'h77, 1, 1, 1, 1);
    add(1, 0, 0, 1, 0, 8'h00, 8'h99, 1, 1, 1, 1);
    add(1, 0, 0, 1, 0, 8'h00, 8'h77, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 8'h00, 8'h77, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 8'hAA, 8'hAA, 1, 1, 1, 1);
    add(1, 0, 1, 0, 1, 8'hBB, 8'hAA, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 8'hC1, 8'hC1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 8'hC2, 8'hC1, 1, 1, 1, 0);
    add(0, 1, 1, 1, 0, 8'hD0, 8'h00, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge p_phi2);
      h_rst_b = vecs[i].rst_n; two_byte_mode = vecs[i].mode;
      h_selectData = vecs[i].wr; h_rdnw = !vecs[i].wr; h_data = vecs[i].d;
      p_selectData = vecs[i].rd; p_rdnw = vecs[i].rd; p_flush = vecs[i].flush;
      @(posedge p_phi2);
      #1;
      idle();
      h_rst_b = 1'b1;
      #1;
      chk($sformatf("vec%0d p_data", i), 32'(p_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d avail", i), 32'(p_data_available), 32'(vecs[i].exp_av));
      chk($sformatf("vec%0d h_full", i), 32'(h_full), 32'(vecs[i].exp_full));
      chk($sformatf("vec%0d p_nmi", i), 32'(p_nmi), 32'(vecs[i].exp_nmi));
      chk($sformatf("vec%0d overrun", i), 32'(h_overrun), 32'(vecs[i].exp_ovr));
    end

    // p_flush masks the NMI combinationally while the buffer is still full.
    @(negedge p_phi2);
    two_byte_mode = 1'b0; h_selectData = 1'b1; h_rdnw = 1'b0; h_data = 8'hE1;
    @(posedge p_phi2); #1; idle(); #1;
    chk("flush_seq full_before", 32'(h_full), 32'd1);
    chk("flush_seq nmi_before", 32'(p_nmi), 32'd1);
    @(negedge p_phi2);
    p_flush = 1'b1;
    #1;
    chk("flush_seq nmi_masked", 32'(p_nmi), 32'd0);
    chk("flush_seq full_held", 32'(h_full), 32'd1);
    @(posedge p_phi2); #1; idle(); #1;
    chk("flush_seq avail_after", 32'(p_data_available), 32'd0);
    chk("flush_seq data_kept", 32'(p_data), 32'hE1);

    // Randomized run against the queue model.
    @(negedge p_phi2);
    h_rst_b = 1'b0;
    @(posedge p_phi2);
    model_step();
    for (int c = 0; c < 3000; c++) begin
      int         cap, n;
      logic [7:0] ed;
      @(negedge p_phi2);
      h_rst_b       = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) == 0) two_byte_mode = ~two_byte_mode;
      h_selectData  = $urandom_range(0, 1);
      h_rdnw        = ($urandom_range(0, 3) == 0);
      h_data        = 8'($urandom);
      p_selectData  = $urandom_range(0, 1);
      p_rdnw        = ($urandom_range(0, 3) != 0);
      p_flush       = ($urandom_range(0, 19) == 0);
      #1;
      cap = two_byte_mode ? 2 : 1;
      n   = q.size();
      ed  = (n != 0) ? q[0] : m[rd_tot % 2];
      chk("rand p_data", 32'(p_data), 32'(ed));
      chk("rand avail", 32'(p_data_available), 32'(n != 0));
      chk("rand h_full", 32'(h_full), 32'(n >= cap));
      chk("rand p_nmi", 32'(p_nmi), 32'((n >= cap) && !p_flush));
      chk("rand overrun", 32'(h_overrun), 32'(ovr));
      @(posedge p_phi2);
      model_step();
    end

    @(negedge p_phi2);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
